jk_reg_arbiter: RTL
===================

JK_REG_ARBITER -- requirements
Module: jk_reg_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; legal values 2..8.
REQ-002 Parameter WIDTH, default 8: width of the shared JK register bank.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset; asynchronous and active-low.
REQ-005 Port req, input, NREQ: per-requester request, level, held until the matching gnt bit is seen.
REQ-006 Port op, input, 2*NREQ: per-requester {j,k} code; bits [2i+1:2i] belong to requester i.
REQ-007 Port mask, input, WIDTH*NREQ: per-requester bit-enable; slice [WIDTH*i +: WIDTH] belongs to requester i.
REQ-008 Port gnt, output, NREQ: one-hot grant, at most one bit high, one-cycle pulse.
REQ-009 Port done, output, 1: one-cycle pulse in the cycle the latched operation is applied.
REQ-010 Port q, output, WIDTH: shared JK register bank contents.

Function
REQ-011 The FSM SHALL have three states: IDLE, GRANT and APPLY.
REQ-012 In IDLE with any req bit high, the round-robin winner SHALL be chosen; its index, op and mask latched; state -> GRANT.
REQ-013 Round-robin SHALL search from pointer ptr upward with wrap (ptr, ptr+1, ..., NREQ-1, 0, ...); on entry to GRANT, ptr <= (winner+1) mod NREQ.
REQ-014 In GRANT, gnt[winner] SHALL be 1 for exactly that cycle; state -> APPLY unconditionally.
REQ-015 In APPLY, done SHALL be 1, and on the closing edge each bit with latched mask=1 updates per JK rule: 00 hold, 01 clear, 10 set, 11 toggle; mask=0 bits hold.
REQ-016 From APPLY, any req high SHALL select a new winner and go directly to GRANT; otherwise go to IDLE.
REQ-017 Latency: req high at edge N -> gnt high in cycle N+1 -> done high and q updated at edge N+2; sustained throughput one operation per 2 cycles.
REQ-018 op and mask SHALL be sampled only at winner selection; later changes and req deassertion after selection SHALL NOT affect the in-flight operation.
REQ-019 mask all-zero SHALL still produce gnt and done with q unchanged.
REQ-020 With no req, the FSM SHALL remain in IDLE with gnt=0, done=0, and q held.

Reset
REQ-021 On rst_n low, asynchronously: q=0, gnt=0, done=0, state=IDLE, ptr=0, latched op/mask/index=0.
REQ-022 Reset during GRANT or APPLY SHALL abort the operation with no q update; the first post-reset arbitration starts at requester 0.

Configuration
REQ-023 With macro JK_REG_ARBITER_STATS_EN defined, output port gnt_cnt (8*NREQ) SHALL be present: a per-requester 8-bit count of grants, saturating at 255 and cleared by reset.
REQ-024 Without JK_REG_ARBITER_STATS_EN, gnt_cnt and its counters SHALL NOT exist; all other behaviour SHALL be identical.

Structure
REQ-025 Package jk_reg_arbiter_pkg SHALL hold the op code constants (OP_HOLD=00, OP_CLR=01, OP_SET=10, OP_TGL=11) and the FSM state typedef.
REQ-026 The round-robin search SHALL be a combinational sub-module jk_rr_pick (inputs req and ptr; outputs valid and winner index).

Verification
REQ-027 Reset, then req=0001, op0=10, mask0=0x0F -> gnt=0001 for one cycle, done next cycle, q=0x0F.
REQ-028 q=0x0F; req0 op=11 mask=0xFF -> q=0xF0; then req2 op=01 mask=0xF0 -> q=0x00; gnt=0100 on the second grant.
REQ-029 req=1111 held, each requester dropping req after its gnt -> grant order 0,1,2,3, gnt pulses 2 cycles apart, no cycle with gnt and done both idle between them.
REQ-030 ptr=3 after grant to 2; req=1001 -> requester 3 first, then 0 (wrap).
REQ-031 rst_n low in APPLY of a set op with mask=0xFF -> q=0x00, done=0, next grant to requester 0.
REQ-032 With STATS_EN, requester 1 granted 300 times -> gnt_cnt[15:8]=255; without STATS_EN, the module builds with no gnt_cnt port.

Source files
------------

// File: rtl/jk_reg_arbiter_pkg.sv
// Shared definitions for the JK register arbiter: JK op codes and FSM states.
package jk_reg_arbiter_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    APPLY = 2'd2
  } state_t;

endpackage

// File: rtl/jk_rr_pick.sv
// Combinational round-robin search: first asserted req at or above ptr, with wrap.
module jk_rr_pick
  import jk_reg_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   winner
);

  // Scan ptr, ptr+1, ... modulo NREQ and keep the first hit.
  always_comb begin : search
    int unsigned k;
    logic [IW-1:0] cand;
    valid  = 1'b0;
    winner = '0;
    k      = 0;
    cand   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k    = (32'(ptr) + i) % 32'(NREQ);
      cand = IW'(k);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/jk_reg_arbiter.sv
// Round-robin arbiter granting NREQ requesters masked JK updates of a shared
// register bank. Optional per-requester grant counters under macro
// JK_REG_ARBITER_STATS_EN (adds port gnt_cnt).
module jk_reg_arbiter
  import jk_reg_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       op,
  input  logic [WIDTH*NREQ-1:0]   mask,
  output logic [NREQ-1:0]         gnt,
  output logic                    done,
  output logic [WIDTH-1:0]        q
`ifdef JK_REG_ARBITER_STATS_EN
  ,
  output logic [8*NREQ-1:0]       gnt_cnt
`endif
);

  localparam int IW = $clog2(NREQ);

  state_t           state, state_nxt;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    idx;
  logic [1:0]       op_l;
  logic [WIDTH-1:0] mask_l;
  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic             load;
  logic [WIDTH-1:0] q_jk;

  jk_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, grant/done pulses and winner-latch enable.
  always_comb begin
    state_nxt = state;
    gnt       = '0;
    done      = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          load      = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        gnt[idx]  = 1'b1;
        state_nxt = APPLY;
      end
      APPLY: begin
        done = 1'b1;
        if (pick_valid) begin
          load      = 1'b1;
          state_nxt = GRANT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch winner, its op and mask at selection; advance the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      op_l   <= OP_HOLD;
      mask_l <= '0;
      ptr    <= '0;
    end else if (load) begin
      idx    <= pick_idx;
      op_l   <= op[{pick_idx, 1'b0} +: 2];
      mask_l <= mask[WIDTH*pick_idx +: WIDTH];
      ptr    <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  // JK result for every bit; the mask selects which bits take it.
  always_comb begin
    q_jk = q;
    case (op_l)
      OP_HOLD: q_jk = q;
      OP_CLR:  q_jk = '0;
      OP_SET:  q_jk = '1;
      OP_TGL:  q_jk = ~q;
      default: q_jk = q;
    endcase
  end

  // Register bank update on the closing edge of APPLY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              q <= '0;
    else if (state == APPLY) q <= (q & ~mask_l) | (q_jk & mask_l);
  end

`ifdef JK_REG_ARBITER_STATS_EN
  // Saturating per-requester grant counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (gnt[i] && gnt_cnt[8*i +: 8] != 8'hFF)
          gnt_cnt[8*i +: 8] <= gnt_cnt[8*i +: 8] + 8'd1;
      end
    end
  end
`endif

endmodule
